// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stage-enable sequencer: debug run/step/halt FSM, load-use bubble
// insertion, branch flush of IF/ID, and advance/stall counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned RNBITS  = 5,
  parameter int unsigned CNTBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_halt_instr,
  input  logic [RNBITS-1:0]  i_id_rs,
  input  logic [RNBITS-1:0]  i_id_rt,
  input  logic [RNBITS-1:0]  i_ex_rt,
  input  logic               i_ex_mem_read,
  input  logic               i_branch_taken,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_en,
  output logic               o_id_ex_flush,
  output logic               o_ex_mem_en,
  output logic               o_mem_wb_en,
  output logic [1:0]         o_state,
  output logic [CNTBITS-1:0] o_cycle_count,
  output logic [CNTBITS-1:0] o_stall_count
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;
  localparam logic [1:0] ST_HALTED = 2'b11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       adv;
  logic       load_use;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; HALTED is left only through reset
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_run)       state_nxt = ST_RUN;
        else if (i_step) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (i_halt_instr) state_nxt = ST_HALTED;
        else if (!i_run)  state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (i_halt_instr) state_nxt = ST_HALTED;
        else              state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  // Reset cycle never advances, even if the registered state is RUN/STEP
  assign adv      = !i_reset && ((state == ST_RUN) || (state == ST_STEP));
  assign load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  // Stage enables; a load-use bubble freezes PC and IF/ID and outranks branch flush
  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    if (adv) begin
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
      o_mem_wb_en = 1'b1;
      if (load_use) begin
        o_id_ex_flush = 1'b1;
      end else begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = i_branch_taken;
      end
    end
  end

  // Debug counters, free-running modulo 2^CNTBITS
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cycle_count <= '0;
      o_stall_count <= '0;
    end else if (adv) begin
      o_cycle_count <= o_cycle_count + CNTBITS'(1);
      if (load_use) o_stall_count <= o_stall_count + CNTBITS'(1);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_run, i_step, i_halt_instr;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_rt;
  logic        i_ex_mem_read, i_branch_taken;
  logic        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic        o_ex_mem_en, o_mem_wb_en;
  logic [1:0]  o_state;
  logic [31:0] o_cycle_count, o_stall_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.RNBITS(5), .CNTBITS(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_halt_instr(i_halt_instr), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_rt(i_ex_rt), .i_ex_mem_read(i_ex_mem_read),
    .i_branch_taken(i_branch_taken), .o_pc_en(o_pc_en),
    .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en), .o_state(o_state),
    .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 one step pending, 3 halted
  int          m_mode  = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_cyc   = '0;
  logic [31:0] m_stl   = '0;

  function automatic bit hazard();
    return i_ex_mem_read && (i_ex_rt != 0) && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
  endfunction

  function automatic bit advancing();
    return !i_reset && (m_mode == 1 || m_mode == 2);
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_mode  <= 0;
      m_cyc   <= '0;
      m_stl   <= '0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (advancing()) begin
        m_cyc <= m_cyc + 1;
        if (hazard()) m_stl <= m_stl + 1;
      end
      if (m_mode == 0)      m_mode <= i_run ? 1 : (i_step ? 2 : 0);
      else if (m_mode == 1) m_mode <= i_halt_instr ? 3 : (i_run ? 1 : 0);
      else if (m_mode == 2) m_mode <= i_halt_instr ? 3 : 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge i_clk) begin
    if (m_valid) begin
      bit a, h;
      a = advancing();
      h = hazard();
      chk("state",        32'(o_state),       32'(m_mode));
      chk("pc_en",        32'(o_pc_en),       32'(a && !h));
      chk("if_id_en",     32'(o_if_id_en),    32'(a && !h));
      chk("if_id_flush",  32'(o_if_id_flush), 32'(a && !h && i_branch_taken));
      chk("id_ex_en",     32'(o_id_ex_en),    32'(a));
      chk("id_ex_flush",  32'(o_id_ex_flush), 32'(a && h));
      chk("ex_mem_en",    32'(o_ex_mem_en),   32'(a));
      chk("mem_wb_en",    32'(o_mem_wb_en),   32'(a));
      chk("cycle_count",  o_cycle_count,      m_cyc);
      chk("stall_count",  o_stall_count,      m_stl);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_hazard();
    i_id_rs = '0; i_id_rt = '0; i_ex_rt = '0;
    i_ex_mem_read = 1'b0; i_branch_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] c0;
    i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_halt_instr = 1'b0;
    clr_hazard();

    // Reset then idle
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (5) tick();
    chk("lit_idle_state", 32'(o_state), 32'd0);
    chk("lit_idle_pc_en", 32'(o_pc_en), 32'd0);
    chk("lit_idle_cycles", o_cycle_count, 32'd0);

    // Continuous run, 10 advances
    i_run = 1'b1;
    tick();
    chk("lit_run_state", 32'(o_state), 32'd1);
    repeat (10) tick();
    chk("lit_run_cycles", o_cycle_count, 32'd10);
    i_run = 1'b0;
    tick();
    chk("lit_run_drop_state", 32'(o_state), 32'd0);
    chk("lit_run_drop_cycles", o_cycle_count, 32'd11);

    // Load-use, rt=0 exemption, branch vs load-use
    i_run = 1'b1;
    tick();
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd5; i_id_rs = 5'd5;
    #1;
    chk("lit_lu_pc_en", 32'(o_pc_en), 32'd0);
    chk("lit_lu_if_id_en", 32'(o_if_id_en), 32'd0);
    chk("lit_lu_id_ex_flush", 32'(o_id_ex_flush), 32'd1);
    chk("lit_lu_ex_mem_en", 32'(o_ex_mem_en), 32'd1);
    tick();
    chk("lit_lu_stalls", o_stall_count, 32'd1);
    i_ex_rt = 5'd0; i_id_rs = 5'd0;
    #1;
    chk("lit_r0_pc_en", 32'(o_pc_en), 32'd1);
    chk("lit_r0_id_ex_flush", 32'(o_id_ex_flush), 32'd0);
    tick();
    chk("lit_r0_stalls", o_stall_count, 32'd1);
    clr_hazard();
    i_branch_taken = 1'b1;
    #1;
    chk("lit_br_flush", 32'(o_if_id_flush), 32'd1);
    chk("lit_br_pc_en", 32'(o_pc_en), 32'd1);
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd7; i_id_rt = 5'd7;
    #1;
    chk("lit_brlu_if_id_flush", 32'(o_if_id_flush), 32'd0);
    chk("lit_brlu_id_ex_flush", 32'(o_id_ex_flush), 32'd1);
    tick();
    chk("lit_brlu_stalls", o_stall_count, 32'd2);
    clr_hazard();
    i_run = 1'b0;
    tick();

    // Single step from IDLE
    c0 = m_cyc;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("lit_step_state", 32'(o_state), 32'd2);
    chk("lit_step_pc_en", 32'(o_pc_en), 32'd1);
    tick();
    chk("lit_step_back_idle", 32'(o_state), 32'd0);
    chk("lit_step_cycles", o_cycle_count, c0 + 32'd1);
    chk("lit_step_pc_off", 32'(o_pc_en), 32'd0);
    i_run = 1'b1; i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("lit_run_beats_step", 32'(o_state), 32'd1);

    // Halt: HALT cycle still advances, then frozen until reset
    i_halt_instr = 1'b1;
    #1;
    chk("lit_halt_cycle_pc_en", 32'(o_pc_en), 32'd1);
    tick();
    i_halt_instr = 1'b0;
    chk("lit_halted_state", 32'(o_state), 32'd3);
    chk("lit_halted_pc_en", 32'(o_pc_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      i_step = i[0];
      tick();
    end
    i_step = 1'b0;
    chk("lit_halted_sticky", 32'(o_state), 32'd3);
    chk("lit_halted_mem_wb", 32'(o_mem_wb_en), 32'd0);
    i_reset = 1'b1;
    #1;
    chk("lit_reset_cycle_no_en", 32'(o_mem_wb_en), 32'd0);
    tick();
    i_reset = 1'b0;
    chk("lit_reset_state", 32'(o_state), 32'd0);
    chk("lit_reset_cycles", o_cycle_count, 32'd0);
    chk("lit_reset_stalls", o_stall_count, 32'd0);

    // Randomized phase; small register range makes hazards frequent
    for (int n = 0; n < 3000; n++) begin
      i_reset        = ($urandom_range(0, 59) == 0);
      i_run          = ($urandom_range(0, 3) != 0);
      i_step         = ($urandom_range(0, 2) == 0);
      i_halt_instr   = ($urandom_range(0, 49) == 0);
      i_id_rs        = 5'($urandom_range(0, 3));
      i_id_rt        = 5'($urandom_range(0, 3));
      i_ex_rt        = 5'($urandom_range(0, 3));
      i_ex_mem_read  = ($urandom_range(0, 1) == 0);
      i_branch_taken = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage MIPS pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It runs a debug execution FSM (idle / continuous run / single step / halted) that gates every stage enable. It detects load-use hazards and inserts a one-cycle bubble into ID/EX. It flushes IF/ID on taken branches and keeps cycle and stall counters for the debug unit.

Parameters:
RNBITS, 5, register-index width
CNTBITS, 32, width of the cycle and stall counters

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  synchronous reset, active-high
i_run  in  1  level; 1 = continuous execution requested
i_step  in  1  single-cycle pulse; request one pipeline advance
i_halt_instr  in  1  HALT instruction present in MEM/WB this cycle
i_id_rs  in  RNBITS  rs field of the instruction in ID
i_id_rt  in  RNBITS  rt field of the instruction in ID
i_ex_rt  in  RNBITS  destination rt of the instruction in EX
i_ex_mem_read  in  1  instruction in EX is a load
i_branch_taken  in  1  branch or jump resolved taken in ID
o_pc_en  out  1  PC write enable
o_if_id_en  out  1  IF/ID load enable
o_if_id_flush  out  1  IF/ID clear to NOP on this edge
o_id_ex_en  out  1  ID/EX load enable
o_id_ex_flush  out  1  ID/EX loads a bubble (all control zero)
o_ex_mem_en  out  1  EX/MEM load enable
o_mem_wb_en  out  1  MEM/WB load enable
o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
o_cycle_count  out  CNTBITS  number of advance cycles since reset
o_stall_count  out  CNTBITS  number of load-use bubbles since reset

Behaviour:
- Single clock domain. i_reset is synchronous, active-high, and has priority over all other inputs. On reset: state IDLE, both counters 0.
- Reset values of the outputs: all enables 0, both flushes 0, o_state 00.
- State register and counters are flops. Enable and flush outputs are combinational from the registered state and the current hazard inputs, so they take effect on the same edge.
- adv = (state==RUN) or (state==STEP).
- FSM transitions:
  - IDLE: i_run -> RUN; else i_step -> STEP; else stay. i_run wins over a simultaneous i_step.
  - RUN: i_halt_instr -> HALTED; else !i_run -> IDLE; else stay. i_step is ignored.
  - STEP: exactly one advance cycle. i_halt_instr -> HALTED, else IDLE. A held i_step does not re-trigger until the FSM is back in IDLE and i_step is sampled again.
  - HALTED: absorbing. Leaves only on i_reset. All inputs are ignored.
- Halt timing: the cycle in which i_halt_instr is seen still advances, so the HALT retires. From the next cycle all enables are 0.
- load_use = i_ex_mem_read and (i_ex_rt != 0) and (i_ex_rt==i_id_rs or i_ex_rt==i_id_rt).
- When !adv: every enable and flush is 0, and the counters hold.
- When adv and load_use:
  - o_pc_en=0, o_if_id_en=0
  - o_id_ex_en=1, o_id_ex_flush=1
  - o_ex_mem_en=1, o_mem_wb_en=1
  - o_if_id_flush=0; load-use takes priority over branch taken
  - o_stall_count +1
- When adv and !load_use and i_branch_taken: all enables are 1 and o_if_id_flush=1.
- When adv with no hazard: all enables are 1 and both flushes are 0.
- o_cycle_count increments on every adv cycle. It wraps modulo 2^CNTBITS. o_stall_count also wraps.
- A stall performed in STEP consumes the step: one step = one clock of advance, bubble included.
- Reset asserted mid-RUN or mid-STEP: the next edge yields IDLE with counters at 0. No enable is asserted in the reset cycle.

Test Plan:
- Reset then idle: i_reset=1 for 2 cycles, then i_run=0 and i_step=0 for 5 cycles -> o_state=00, all enables 0, o_cycle_count=0.
- Continuous run: i_run=1 for 10 cycles, no hazards -> o_state=01 from cycle 1. All enables 1 on 10 consecutive cycles. o_cycle_count=10 after the 10th advance edge. Drop i_run -> o_state=00.
- Load-use in RUN: i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 for one cycle -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1, o_stall_count=1. Repeat with i_ex_rt=0 -> no stall.
- Branch versus load-use: i_branch_taken=1 alone -> o_if_id_flush=1, all enables 1. i_branch_taken=1 together with a load-use -> o_if_id_flush=0, o_id_ex_flush=1.
- Single step: from IDLE, pulse i_step for 1 cycle -> exactly one cycle with enables 1, o_cycle_count +1, then IDLE. i_run and i_step together in IDLE -> RUN.
- Halt: in RUN assert i_halt_instr for one cycle -> that cycle has enables 1, then o_state=11 with all enables 0 despite i_run=1 and i_step pulses. i_reset -> IDLE with counters at 0.
